mmio_controller: RTL and testbench

Memory-mapped I/O controller between the processor's data-memory port and the data RAM, switch inputs and LED outputs. It decodes each bus request, sequences the access through a small FSM with a valid/ack handshake, and inserts a wait state for synchronous RAM reads. It also synchronises and debounces the switches, registers the LEDs, and keeps a sticky status register. It sits inside `top` and drives the board-level `switches`/`leds` pins.

---
 rtl/mmio_controller_if.sv | 20 ++
 rtl/mmio_controller.sv | 169 ++++++++++++++++
 tb/tb_mmio_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mmio_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_controller_if
// Description : Processor data-memory bus seen by the MMIO controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_controller_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, output we, output addr, output wdata,
                    input  rdata, input ack);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output rdata, output ack);
endinterface
`default_nettype wire

// File: rtl/mmio_controller.sv
`default_nettype none
// ============================================================================
// Module      : mmio_controller
// Description : Bus decode/sequencing to RAM, debounced switches, LEDs, status.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_controller #(
    parameter int          SW_WIDTH  = 10,
    parameter int          LED_WIDTH = 10,
    parameter int          RAM_WORDS = 256,
    parameter int          DEBOUNCE  = 4,
    parameter logic [31:0] SW_ADDR   = 32'hC000_0000,
    parameter logic [31:0] LED_ADDR  = 32'hC000_0004,
    parameter logic [31:0] STAT_ADDR = 32'hC000_0008
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    mmio_controller_if.slave                  bus,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [$clog2(RAM_WORDS)-1:0]      mem_addr,
    output logic [31:0]                       mem_wdata,
    input  wire logic [31:0]                  mem_rdata,
    input  wire logic [SW_WIDTH-1:0]          switches,
    output logic [LED_WIDTH-1:0]              leds
);
    localparam int          AW          = $clog2(RAM_WORDS);
    localparam int          CW          = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [31:0] C_RAM_BYTES = 32'(4 * RAM_WORDS);
    localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic                 we_q, we_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          resp_q, resp_d;
    logic [LED_WIDTH-1:0] leds_q, leds_d;
    logic [SW_WIDTH-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [SW_WIDTH-1:0]  cand_q, cand_d, sw_reg_q, sw_reg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 bus_err_q, bus_err_d, sw_event_q, sw_event_d;

    logic w_is_ram, w_is_sw, w_is_led, w_is_stat, w_is_err;
    logic w_err_set, w_evt_set, w_stat_clr;
    logic [31:0] w_status;

    // Decode always works from the latched request, never the live bus.
    assign w_is_ram  = (addr_q[1:0] == 2'b00) && (addr_q < C_RAM_BYTES);
    assign w_is_sw   = (addr_q == SW_ADDR);
    assign w_is_led  = (addr_q == LED_ADDR);
    assign w_is_stat = (addr_q == STAT_ADDR);
    assign w_is_err  = !(w_is_ram || w_is_sw || w_is_led || w_is_stat);
    assign w_status  = {30'b0, bus_err_q, sw_event_q};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        leds_d     = leds_q;
        w_err_set  = 1'b0;
        w_stat_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    we_d    = bus.we;
                    wdata_d = bus.wdata;
                    resp_d  = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (w_is_ram) begin
                    if (!we_q) state_d = WAIT;
                end else if (w_is_err) begin
                    w_err_set = 1'b1;
                end else if (we_q) begin
                    if (w_is_led) leds_d = wdata_q[LED_WIDTH-1:0];
                end else if (w_is_sw) begin
                    resp_d = 32'(sw_reg_q);
                end else if (w_is_led) begin
                    resp_d = 32'(leds_q);
                end else begin
                    resp_d     = w_status;
                    w_stat_clr = 1'b1;
                end
            end
            WAIT: begin
                resp_d  = mem_rdata;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Switch synchroniser and debounce; sticky status with set-over-clear.
    always_comb begin
        sync1_d   = switches;
        sync2_d   = sync1_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        sw_reg_d  = sw_reg_q;
        w_evt_set = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != C_CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cand_q != sw_reg_q) begin
            sw_reg_d  = cand_q;
            w_evt_set = 1'b1;
        end
        bus_err_d  = w_err_set || (bus_err_q && !w_stat_clr);
        sw_event_d = w_evt_set || (sw_event_q && !w_stat_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            resp_q     <= '0;
            leds_q     <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            sw_reg_q   <= '0;
            bus_err_q  <= 1'b0;
            sw_event_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            leds_q     <= leds_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            sw_reg_q   <= sw_reg_d;
            bus_err_q  <= bus_err_d;
            sw_event_q <= sw_event_d;
        end
    end

    assign bus.ack   = (state_q == RESP);
    assign bus.rdata = (state_q == RESP) ? resp_q : 32'd0;
    assign mem_en    = (state_q == ACCESS) && w_is_ram;
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q[2 +: AW];
    assign mem_wdata = wdata_q;
    assign leds      = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_controller
// Description : Directed self-checking bench for mmio_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_controller;
    localparam logic [31:0] SW_A   = 32'hC000_0000;
    localparam logic [31:0] LED_A  = 32'hC000_0004;
    localparam logic [31:0] STAT_A = 32'hC000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [9:0]  switches, leds;

    logic [31:0] ram [256];
    int          en_cnt = 0;
    int          en_before;
    logic        acc_en, acc_we;
    logic [7:0]  acc_addr;
    int          vectors = 0;
    int          errors  = 0;

    mmio_controller_if bus ();

    mmio_controller dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .switches  (switches),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en) mem_rdata <= ram[mem_addr];
        if (mem_en) en_cnt <= en_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; ack is expected exactly lat cycles after issue.
    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int lat, input logic [31:0] exp);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        for (int i = 1; i < lat; i++) begin
            tick();
            if (i == 1) begin
                acc_en   = mem_en;
                acc_we   = mem_we;
                acc_addr = mem_addr;
            end
            chk({tag, "_noack"}, 32'(bus.ack), 32'd0);
        end
        tick();
        chk({tag, "_ack"}, 32'(bus.ack), 32'd1);
        chk({tag, "_rdata"}, bus.rdata, exp);
        bus.req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        mem_rdata = 32'd0;
        reset     = 1'b1;
        switches  = 10'd0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
        repeat (3) tick();
        chk("rst_ack",    32'(bus.ack), 32'd0);
        chk("rst_rdata",  bus.rdata,    32'd0);
        chk("rst_leds",   32'(leds),    32'd0);
        chk("rst_mem_en", 32'(mem_en),  32'd0);
        reset = 1'b0;

        switches = 10'd4;
        repeat (10) tick();
        access("sw_rd",    1'b0, SW_A,   32'd0, 2, 32'd4);
        access("stat_rd1", 1'b0, STAT_A, 32'd0, 2, 32'd1);
        access("stat_rd2", 1'b0, STAT_A, 32'd0, 2, 32'd0);

        access("led_wr", 1'b1, LED_A, 32'h0000_02A5, 2, 32'd0);
        chk("led_val", 32'(leds), 32'h2A5);
        access("led_rd", 1'b0, LED_A, 32'd0, 2, 32'h2A5);

        en_before = en_cnt;
        access("ram_wr", 1'b1, 32'h10, 32'hDEAD_BEEF, 2, 32'd0);
        chk("ram_wr_en",   32'(acc_en),   32'd1);
        chk("ram_wr_we",   32'(acc_we),   32'd1);
        chk("ram_wr_addr", 32'(acc_addr), 32'd4);
        chk("ram_wr_pulses", 32'(en_cnt - en_before), 32'd1);
        en_before = en_cnt;
        access("ram_rd", 1'b0, 32'h10, 32'd0, 3, 32'hDEAD_BEEF);
        chk("ram_rd_en",   32'(acc_en),   32'd1);
        chk("ram_rd_we",   32'(acc_we),   32'd0);
        chk("ram_rd_addr", 32'(acc_addr), 32'd4);
        chk("ram_rd_pulses", 32'(en_cnt - en_before), 32'd1);

        // Glitch one cycle shorter than the debounce window.
        switches = 10'd5;
        repeat (3) tick();
        switches = 10'd4;
        repeat (12) tick();
        access("glitch_sw",   1'b0, SW_A,   32'd0, 2, 32'd4);
        access("glitch_stat", 1'b0, STAT_A, 32'd0, 2, 32'd0);

        access("err_hi",    1'b0, 32'h8000_0000, 32'd0, 2, 32'd0);
        access("err_align", 1'b0, 32'h0000_0002, 32'd0, 2, 32'd0);
        access("err_stat",  1'b0, STAT_A,        32'd0, 2, 32'd2);
        access("sw_wr",     1'b1, SW_A,   32'hFFFF_FFFF, 2, 32'd0);
        access("sw_wr_stat",1'b0, STAT_A, 32'd0,         2, 32'd0);

        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 32'h10;
        tick();
        chk("mid_mem_en", 32'(mem_en), 32'd1);
        reset   = 1'b1;
        bus.req = 1'b0;
        tick();
        reset = 1'b0;
        chk("mid_ack0",  32'(bus.ack),     32'd0);
        chk("mid_state", 32'(dut.state_q), 32'd0);
        chk("mid_leds",  32'(leds),        32'd0);
        tick();
        chk("mid_ack1", 32'(bus.ack), 32'd0);
        tick();
        chk("mid_ack2", 32'(bus.ack), 32'd0);
        access("post_rst_rd", 1'b0, 32'h10, 32'd0, 3, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
